fft_bf_sched: RTL and testbench

Butterfly scheduler for the 32-point in-place radix-2 DIT FFT. After bit-reversed input samples are loaded into the data RAM, it sequences 5 stages × 16 butterflies. For each butterfly it drives the operand RAM addresses and the twiddle ROM index (W0..W15). It also tracks the butterfly pipeline so write-back addresses line up with results, and it holds off each new stage until the previous stage's writes have drained.

---
 rtl/fft_bf_sched_if.sv | 21 ++
 rtl/fft_bf_sched.sv | 178 +++++++++++++++++
 tb/tb_fft_bf_sched.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bf_sched_if.sv
// rtl/fft_bf_sched_if.sv - issue and write-back bus between the butterfly scheduler and butterfly unit
interface fft_bf_sched_if;
    logic       bf_valid;
    logic       bf_ready;
    logic [4:0] addr_a;
    logic [4:0] addr_b;
    logic [3:0] tw_idx;
    logic       wr_en;
    logic [4:0] wr_addr_a;
    logic [4:0] wr_addr_b;

    modport master (
        output bf_valid, addr_a, addr_b, tw_idx, wr_en, wr_addr_a, wr_addr_b,
        input  bf_ready
    );

    modport slave (
        input  bf_valid, addr_a, addr_b, tw_idx, wr_en, wr_addr_a, wr_addr_b,
        output bf_ready
    );
endinterface

// File: rtl/fft_bf_sched.sv
// rtl/fft_bf_sched.sv - 32-point radix-2 DIT FFT butterfly issue and write-back scheduler
module fft_bf_sched #(
    parameter int BF_LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    fft_bf_sched_if.master bf,
    output logic [2:0]     stage,
    output logic           busy,
    output logic           done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    // Operand addresses and twiddle index for butterfly kk of stage s, packed {a, b, tw}.
    function automatic logic [13:0] bf_map(input logic [2:0] s, input logic [3:0] kk);
        logic [4:0] span;
        logic [4:0] pos;
        logic [4:0] grp;
        logic [4:0] a;
        logic [4:0] b;
        logic [3:0] tw;
        span = 5'd1 << s;
        pos  = {1'b0, kk} & (span - 5'd1);
        grp  = {1'b0, kk} >> s;
        a    = (grp << (s + 3'd1)) | pos;
        b    = a + span;
        tw   = pos[3:0] << (3'd4 - s);
        return {a, b, tw};
    endfunction

    state_t     state;
    logic [3:0] k;
    logic       bf_valid_q;
    logic [4:0] addr_a_q;
    logic [4:0] addr_b_q;
    logic [3:0] tw_q;

    // Write-back pipeline: entry 0 is loaded at the accept edge, entry BF_LAT-1 drives wr_en.
    logic [BF_LAT-1:0]      pipe_v;
    logic [BF_LAT-1:0]      pipe_last;
    logic [BF_LAT-1:0][4:0] pipe_a;
    logic [BF_LAT-1:0][4:0] pipe_b;
    logic [BF_LAT-1:0]      v_next;
    logic [BF_LAT-1:0]      last_next;
    logic [BF_LAT-1:0][4:0] a_next;
    logic [BF_LAT-1:0][4:0] b_next;

    logic       accept;
    logic       last_wr;
    logic [4:0] nk_a;
    logic [4:0] nk_b;
    logic [3:0] nk_tw;
    logic [4:0] ns_a;
    logic [4:0] ns_b;
    logic [3:0] ns_tw;

    assign accept  = bf_valid_q & bf.bf_ready;
    assign last_wr = pipe_v[BF_LAT-1] & pipe_last[BF_LAT-1];

    // Next butterfly within this stage, and first butterfly of the following stage.
    assign {nk_a, nk_b, nk_tw} = bf_map(stage, k + 4'd1);
    assign {ns_a, ns_b, ns_tw} = bf_map(stage + 3'd1, 4'd0);

    assign bf.bf_valid  = bf_valid_q;
    assign bf.addr_a    = addr_a_q;
    assign bf.addr_b    = addr_b_q;
    assign bf.tw_idx    = tw_q;
    assign bf.wr_en     = pipe_v[BF_LAT-1];
    assign bf.wr_addr_a = pipe_a[BF_LAT-1];
    assign bf.wr_addr_b = pipe_b[BF_LAT-1];

    if (BF_LAT == 1) begin : g_lat1
        assign v_next    = accept;
        assign last_next = (k == 4'd15);
        assign a_next    = addr_a_q;
        assign b_next    = addr_b_q;
    end else begin : g_latn
        assign v_next    = {pipe_v[BF_LAT-2:0], accept};
        assign last_next = {pipe_last[BF_LAT-2:0], (k == 4'd15)};
        assign a_next    = {pipe_a[BF_LAT-2:0], addr_a_q};
        assign b_next    = {pipe_b[BF_LAT-2:0], addr_b_q};
    end

    // Butterfly pipeline tracker: shifts every cycle regardless of bf_ready; abort squashes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v    <= '0;
            pipe_last <= '0;
            pipe_a    <= '0;
            pipe_b    <= '0;
        end else begin
            pipe_v    <= abort ? '0 : v_next;
            pipe_last <= last_next;
            pipe_a    <= a_next;
            pipe_b    <= b_next;
        end
    end

    // Stage/butterfly sequencer with registered issue outputs and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= 4'd0;
            stage      <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bf_valid_q <= 1'b0;
            addr_a_q   <= 5'd0;
            addr_b_q   <= 5'd0;
            tw_q       <= 4'd0;
        end else if (abort) begin
            state      <= IDLE;
            k          <= 4'd0;
            stage      <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bf_valid_q <= 1'b0;
            addr_a_q   <= 5'd0;
            addr_b_q   <= 5'd0;
            tw_q       <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ISSUE;
                        stage      <= 3'd0;
                        k          <= 4'd0;
                        busy       <= 1'b1;
                        bf_valid_q <= 1'b1;
                        addr_a_q   <= 5'd0;
                        addr_b_q   <= 5'd1;
                        tw_q       <= 4'd0;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        if (k == 4'd15) begin
                            state      <= DRAIN;
                            bf_valid_q <= 1'b0;
                        end else begin
                            k        <= k + 4'd1;
                            addr_a_q <= nk_a;
                            addr_b_q <= nk_b;
                            tw_q     <= nk_tw;
                        end
                    end
                end
                DRAIN: begin
                    // Wait for the stage's last write so the next stage never reads stale data.
                    if (last_wr) begin
                        if (stage == 3'd4) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state      <= ISSUE;
                            stage      <= stage + 3'd1;
                            k          <= 4'd0;
                            bf_valid_q <= 1'b1;
                            addr_a_q   <= ns_a;
                            addr_b_q   <= ns_b;
                            tw_q       <= ns_tw;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_bf_sched.sv
// tb/tb_fft_bf_sched.sv - scoreboard testbench for fft_bf_sched
module tb_fft_bf_sched;
    typedef struct { int s; int a; int b; int tw; } iss_t;
    typedef struct { int a; int b; int t; } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       start8;
    logic       abort8;
    logic [2:0] stage;
    logic [2:0] stage8;
    logic       busy;
    logic       done;
    logic       busy8;
    logic       done8;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    iss_t exp_iss3[$];
    iss_t exp_iss8[$];
    wr_t  exp_wr3[$];
    wr_t  exp_wr8[$];
    int   exp_done3[$];
    int   exp_done8[$];
    int   acc_n3 = 0;
    int   wr_n3 = 0;
    int   wr_n8 = 0;
    int   inflight8 = 0;
    int   last_wr8 = 0;
    int   exp_stage8 = 0;
    int   cap_a[5][16];
    int   cap_b[5][16];
    int   cap_tw[5][16];

    fft_bf_sched_if bus3();
    fft_bf_sched_if bus8();

    fft_bf_sched #(.BF_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .bf(bus3.master), .stage(stage), .busy(busy), .done(done)
    );

    fft_bf_sched #(.BF_LAT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8),
        .bf(bus8.master), .stage(stage8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Conventional DIT loop order: groups of 2*span, position p inside a group.
    task automatic push_run(input bit which);
        for (int s = 0; s < 5; s++) begin
            int span = 1 << s;
            for (int g = 0; g < 16 / span; g++) begin
                for (int p = 0; p < span; p++) begin
                    iss_t e;
                    e.s  = s;
                    e.a  = g * 2 * span + p;
                    e.b  = e.a + span;
                    e.tw = p * (16 / span);
                    if (which) exp_iss8.push_back(e);
                    else       exp_iss3.push_back(e);
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bf_valid"},  bus3.bf_valid, 0);
        check({tag, "_wr_en"},     bus3.wr_en, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_addr_a"},    bus3.addr_a, 0);
        check({tag, "_addr_b"},    bus3.addr_b, 0);
        check({tag, "_tw_idx"},    bus3.tw_idx, 0);
        check({tag, "_wr_addr_a"}, bus3.wr_addr_a, 0);
        check({tag, "_wr_addr_b"}, bus3.wr_addr_b, 0);
        check({tag, "_stage"},     stage, 0);
    endtask

    task automatic wait_done(input int lim);
        int t = 0;
        while ((exp_done3.size() != 0 || exp_done8.size() != 0) && t < lim) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("done_in_time", int'(t < lim), 1);
        exp_done3.delete();
        exp_done8.delete();
        repeat (2) @(posedge clk);
        #1;
        check("iss3_drained", exp_iss3.size(), 0);
        check("wr3_drained", exp_wr3.size(), 0);
    endtask

    task automatic wait_stage(input int s, input string name);
        int t = 0;
        while (!(stage == 3'(s) && bus3.bf_valid) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, int'(t < 400), 1);
    endtask

    task automatic pulse_start3();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Monitor for the BF_LAT=3 instance: issue order, hold under backpressure, write-back, done.
    initial begin
        iss_t e;
        wr_t  w;
        int   d;
        bit   held3;
        int   held_a;
        int   held_b;
        int   held_tw;
        held3 = 0;
        held_a = 0;
        held_b = 0;
        held_tw = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held3 = 0;
            end else begin
                if (bus3.bf_valid && held3) begin
                    check("hold_addr_a", bus3.addr_a, held_a);
                    check("hold_addr_b", bus3.addr_b, held_b);
                    check("hold_tw_idx", bus3.tw_idx, held_tw);
                end
                held3 = 0;
                if (bus3.bf_valid && bus3.bf_ready) begin
                    check("issue_expected", int'(exp_iss3.size() > 0), 1);
                    if (exp_iss3.size() > 0) begin
                        e = exp_iss3.pop_front();
                        check("issue_stage", stage, e.s);
                        check("issue_addr_a", bus3.addr_a, e.a);
                        check("issue_addr_b", bus3.addr_b, e.b);
                        check("issue_tw_idx", bus3.tw_idx, e.tw);
                    end
                    if (stage < 3'd5) begin
                        cap_a[stage][acc_n3 % 16]  = bus3.addr_a;
                        cap_b[stage][acc_n3 % 16]  = bus3.addr_b;
                        cap_tw[stage][acc_n3 % 16] = bus3.tw_idx;
                    end
                    acc_n3++;
                    w.a = bus3.addr_a;
                    w.b = bus3.addr_b;
                    w.t = cyc + 3;
                    exp_wr3.push_back(w);
                end else if (bus3.bf_valid) begin
                    held3   = 1;
                    held_a  = bus3.addr_a;
                    held_b  = bus3.addr_b;
                    held_tw = bus3.tw_idx;
                end
                if (bus3.wr_en) begin
                    wr_n3++;
                    check("wr_expected", int'(exp_wr3.size() > 0), 1);
                    if (exp_wr3.size() > 0) begin
                        w = exp_wr3.pop_front();
                        check("wr_addr_a", bus3.wr_addr_a, w.a);
                        check("wr_addr_b", bus3.wr_addr_b, w.b);
                        check("wr_cycle", cyc, w.t);
                    end
                end
                if (done) begin
                    check("done_busy_low", busy, 0);
                    check("done_expected", int'(exp_done3.size() > 0), 1);
                    if (exp_done3.size() > 0) begin
                        d = exp_done3.pop_front();
                        if (d >= 0) check("done_cycle", cyc, d);
                    end
                end
            end
        end
    end

    // Monitor for the BF_LAT=8 instance: stage ordering and drain-before-next-stage.
    initial begin
        iss_t e;
        wr_t  w;
        int   d;
        bit   prev_v8;
        prev_v8 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v8 = 0;
            end else begin
                if (bus8.bf_valid && !prev_v8) begin
                    check("lat8_stage_order", stage8, exp_stage8);
                    check("lat8_no_inflight", inflight8, 0);
                    if (exp_stage8 != 0) check("lat8_turnaround", last_wr8, cyc - 1);
                    exp_stage8++;
                end
                prev_v8 = bus8.bf_valid;
                if (bus8.bf_valid && bus8.bf_ready) begin
                    check("lat8_issue_expected", int'(exp_iss8.size() > 0), 1);
                    if (exp_iss8.size() > 0) begin
                        e = exp_iss8.pop_front();
                        check("lat8_issue_addr_a", bus8.addr_a, e.a);
                        check("lat8_issue_addr_b", bus8.addr_b, e.b);
                    end
                    w.a = bus8.addr_a;
                    w.b = bus8.addr_b;
                    w.t = cyc + 8;
                    exp_wr8.push_back(w);
                    inflight8++;
                end
                if (bus8.wr_en) begin
                    wr_n8++;
                    inflight8--;
                    last_wr8 = cyc;
                    check("lat8_wr_expected", int'(exp_wr8.size() > 0), 1);
                    if (exp_wr8.size() > 0) begin
                        w = exp_wr8.pop_front();
                        check("lat8_wr_addr_a", bus8.wr_addr_a, w.a);
                        check("lat8_wr_cycle", cyc, w.t);
                    end
                end
                if (done8) begin
                    check("lat8_done_expected", int'(exp_done8.size() > 0), 1);
                    if (exp_done8.size() > 0) begin
                        d = exp_done8.pop_front();
                        check("lat8_done_cycle", cyc, d);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        start8 = 1'b0;
        abort8 = 1'b0;
        bus3.bf_ready = 1'b0;
        bus8.bf_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_reset", busy, 0);

        // Full run on both latencies, bf_ready held high.
        push_run(0);
        push_run(1);
        acc_n3 = 0;
        wr_n3 = 0;
        wr_n8 = 0;
        exp_stage8 = 0;
        bus3.bf_ready = 1'b1;
        exp_done3.push_back(cyc + 1 + 95);
        exp_done8.push_back(cyc + 1 + 120);
        start  = 1'b1;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start8 = 1'b0;
        check("start_busy", busy, 1);
        check("start_bf_valid", bus3.bf_valid, 1);
        check("start_addr_b", bus3.addr_b, 1);
        wait_done(300);
        check("full_wr_count", wr_n3, 80);
        check("lat8_wr_count", wr_n8, 80);
        check("lat8_stage_count", exp_stage8, 5);
        check("s0k5_addr_a", cap_a[0][5], 10);
        check("s0k5_addr_b", cap_b[0][5], 11);
        check("s0k5_tw", cap_tw[0][5], 0);
        check("s2k5_addr_a", cap_a[2][5], 9);
        check("s2k5_addr_b", cap_b[2][5], 13);
        check("s2k5_tw", cap_tw[2][5], 4);
        check("s4k15_addr_a", cap_a[4][15], 15);
        check("s4k15_addr_b", cap_b[4][15], 31);
        check("s4k15_tw", cap_tw[4][15], 15);

        // Backpressure: bf_ready high one cycle in three.
        push_run(0);
        acc_n3 = 0;
        wr_n3 = 0;
        exp_done3.push_back(-1);
        bus3.bf_ready = 1'b0;
        pulse_start3();
        begin
            int t = 0;
            while (exp_done3.size() != 0 && t < 1000) begin
                bus3.bf_ready = (t % 3 == 0);
                @(posedge clk);
                #1;
                t++;
            end
            check("bp_done_in_time", int'(t < 1000), 1);
        end
        bus3.bf_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("bp_wr_count", wr_n3, 80);
        check("bp_issue_count", acc_n3, 80);
        check("bp_iss_drained", exp_iss3.size(), 0);

        // Abort in stage 3 with writes in flight.
        push_run(0);
        acc_n3 = 0;
        exp_done3.push_back(cyc + 1 + 95);
        pulse_start3();
        wait_stage(3, "abort_reach_stage3");
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_inflight", int'(exp_wr3.size() >= 2), 1);
        exp_iss3.delete();
        exp_wr3.delete();
        exp_done3.delete();
        check("abort_busy", busy, 0);
        check("abort_bf_valid", bus3.bf_valid, 0);
        check("abort_stage", stage, 0);
        check("abort_wr_en", bus3.wr_en, 0);
        repeat (15) @(posedge clk);
        #1;
        check("abort_idle", bus3.bf_valid, 0);

        // Clean run after abort.
        push_run(0);
        acc_n3 = 0;
        wr_n3 = 0;
        exp_done3.push_back(cyc + 1 + 95);
        pulse_start3();
        wait_done(300);
        check("post_abort_wr_count", wr_n3, 80);

        // start during stage 1 is ignored: done keeps its original schedule.
        push_run(0);
        acc_n3 = 0;
        wr_n3 = 0;
        exp_done3.push_back(cyc + 1 + 95);
        pulse_start3();
        wait_stage(1, "restart_reach_stage1");
        pulse_start3();
        wait_done(300);
        check("restart_wr_count", wr_n3, 80);

        // start and abort together from IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_bf_valid", bus3.bf_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        check("sa_idle_busy", busy, 0);
        check("sa_idle_bf_valid", bus3.bf_valid, 0);

        // Asynchronous reset during stage 2 issue.
        push_run(0);
        acc_n3 = 0;
        exp_done3.push_back(-1);
        pulse_start3();
        wait_stage(2, "reset_reach_stage2");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check_zero("async_reset");
        exp_iss3.delete();
        exp_wr3.delete();
        exp_done3.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_busy", busy, 0);
        check("post_reset_bf_valid", bus3.bf_valid, 0);
        check("post_reset_wr_en", bus3.wr_en, 0);
        check("post_reset_stage", stage, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
